apb_axil_bridge: RTL

APB-completer to AXI4-Lite-manager bridge: the reverse direction of our AXI4-Lite→APB bridge. An APB requester (CPU-side APB fabric) issues one transfer at a time. The block converts each transfer into exactly one AXI4-Lite write (AW+W+B) or read (AR+R) and returns the result with APB wait states. It sits between the peripheral APB segment and AXI4-Lite targets.

---
 rtl/axil_apb_pkg.sv | 31 +++
 rtl/apb_axil_bridge.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/axil_apb_pkg.sv
// Shared definitions for the APB <-> AXI4-Lite bridge pair.
//   RESP_*          : AXI4-Lite response encodings
//   bridge_state_t  : transfer FSM state
//   resp_is_err()   : maps an AXI response to the APB pslverr level
package axil_apb_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    DONE
  } bridge_state_t;

  // SLVERR and DECERR both surface as an APB error; OKAY and EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    resp_is_err = 1'b1;
    case (resp)
      RESP_OKAY, RESP_EXOKAY:   resp_is_err = 1'b0;
      RESP_SLVERR, RESP_DECERR: resp_is_err = 1'b1;
      default:                  resp_is_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/apb_axil_bridge.sv
// APB completer to AXI4-Lite manager bridge.
// Each APB transfer becomes exactly one AXI4-Lite write (AW+W+B) or read
// (AR+R); the APB side is held in wait states until the AXI side finishes.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   psel/penable/pwrite/paddr/
//   pwdata/pstrb/pprot          : APB request
//   pready/prdata/pslverr       : APB completion
//   aw*/w*/b*                   : AXI4-Lite write channels (manager side)
//   ar*/r*                      : AXI4-Lite read channels (manager side)
// Every output is a register.
module apb_axil_bridge
  import axil_apb_pkg::*;
#(
  parameter int dataWidth = 32,
  parameter int addrWidth = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [addrWidth-1:0]   paddr,
  input  logic [dataWidth-1:0]   pwdata,
  input  logic [dataWidth/8-1:0] pstrb,
  input  logic [2:0]             pprot,
  output logic                   pready,
  output logic [dataWidth-1:0]   prdata,
  output logic                   pslverr,
  output logic [addrWidth-1:0]   awaddr,
  output logic [2:0]             awprot,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [dataWidth-1:0]   wdata,
  output logic [dataWidth/8-1:0] wstrb,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic [1:0]             bresp,
  input  logic                   bvalid,
  output logic                   bready,
  output logic [addrWidth-1:0]   araddr,
  output logic [2:0]             arprot,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [dataWidth-1:0]   rdata,
  input  logic [1:0]             rresp,
  input  logic                   rvalid,
  output logic                   rready
);

  bridge_state_t state, next_state;

  logic start;
  logic aw_done, w_done;
  logic awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d, pready_d;

  // A setup phase is only honoured from IDLE; anything seen while busy is ignored.
  assign start = (state == IDLE) && psel && !penable;

  // A channel counts as done once its valid is already low or is handshaking now,
  // so AW and W completing in the same cycle still advance together.
  assign aw_done = !awvalid || awready;
  assign w_done  = !wvalid  || wready;

  // State and control register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (rst) begin
      state   <= IDLE;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      pready  <= 1'b0;
    end else begin
      state   <= next_state;
      awvalid <= awvalid_d;
      wvalid  <= wvalid_d;
      bready  <= bready_d;
      arvalid <= arvalid_d;
      rready  <= rready_d;
      pready  <= pready_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves next_state unassigned
    // (which would infer a latch).
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = pwrite ? WR_REQ : RD_REQ;
      WR_REQ:  if (aw_done && w_done) next_state = WR_RESP;
      WR_RESP: if (bvalid) next_state = DONE;
      RD_REQ:  if (arready) next_state = RD_DATA;
      RD_DATA: if (rvalid) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic: next values of the registered handshake outputs. Valids are
  // raised at the setup edge and only dropped by their own ready.
  always_comb begin
    awvalid_d = (start && pwrite) || (awvalid && !awready);
    wvalid_d  = (start && pwrite) || (wvalid && !wready);
    bready_d  = (next_state == WR_RESP);
    arvalid_d = (next_state == RD_REQ);
    rready_d  = (next_state == RD_DATA);
    pready_d  = (next_state == DONE);
  end

  // Request capture and response latching. Request fields only load at the
  // setup edge, so they stay stable for as long as their valid is high.
  always_ff @(posedge clk) begin
    // NOTE: the datapath is reset as well because its reset values are
    // visible on the ports.
    if (rst) begin
      awaddr  <= '0;
      awprot  <= '0;
      wdata   <= '0;
      wstrb   <= '0;
      araddr  <= '0;
      arprot  <= '0;
      prdata  <= '0;
      pslverr <= 1'b0;
    end else begin
      if (start && pwrite) begin
        awaddr <= paddr;
        awprot <= pprot;
        wdata  <= pwdata;
        wstrb  <= pstrb;
      end
      if (start && !pwrite) begin
        araddr <= paddr;
        arprot <= pprot;
      end
      if (start) begin
        pslverr <= 1'b0;
      end
      if (state == WR_RESP && bvalid) begin
        pslverr <= resp_is_err(bresp);
      end
      // prdata only moves on a read response; writes leave it untouched.
      if (state == RD_DATA && rvalid) begin
        prdata  <= rdata;
        pslverr <= resp_is_err(rresp);
      end
    end
  end

endmodule
